countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: load load_val and begin counting down.
REQ-005 The block SHALL have port load_val, input, WIDTH bits: start value, sampled only on an accepted start.
REQ-006 The block SHALL have port auto_reload, input, 1 bit: reload behaviour at terminal count, sampled at the terminal edge.
REQ-007 The block SHALL have port pause, input, 1 bit: hold the count while high.
REQ-008 The block SHALL have port abort, input, 1 bit: cancel the run, clear the count, produce no done pulse.
REQ-009 The block SHALL have port cnt, output, WIDTH bits: current count value, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN and PAUSED states.
REQ-011 The block SHALL have port done, output, 1 bit: registered one-cycle pulse at terminal count.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and PAUSED.
REQ-013 The decrement SHALL be a ripple chain of half-subtractor cells: bit0 minus constant 1, bit n minus borrow n-1.
REQ-014 Input priority SHALL be evaluated each edge in the order abort > start > pause.
REQ-015 abort=1 in any state SHALL give cnt<=0, state<=IDLE and done<=0.
REQ-016 In IDLE, start=1 with load_val!=0 SHALL give cnt<=load_val, reload_reg<=load_val and state<=RUN.
REQ-017 In IDLE, start=1 with load_val==0 SHALL give cnt<=0 and done<=1 for one cycle; state stays IDLE and busy stays 0.
REQ-018 In IDLE with no start, cnt SHALL hold its value.
REQ-019 start in RUN or PAUSED SHALL be ignored; load_val is not sampled.
REQ-020 In RUN with pause=0 and cnt>1, the block SHALL set cnt<=cnt-1.
REQ-021 In RUN with pause=0 and cnt==1 (terminal edge), the block SHALL set done<=1 and update cnt and state per REQ-022/REQ-023.
REQ-022 At the terminal edge with auto_reload=0, the block SHALL set cnt<=0 and state<=IDLE; busy falls on that same edge.
REQ-023 At the terminal edge with auto_reload=1, the block SHALL set cnt<=reload_reg and stay in RUN.
REQ-024 In RUN with pause=1, the block SHALL go to PAUSED with cnt held; no decrement occurs on that edge.
REQ-025 In PAUSED, cnt SHALL hold while pause=1; pause=0 SHALL give state<=RUN, and decrementing resumes on the following edge.
REQ-026 done SHALL be 0 on every edge except those in REQ-017 and REQ-021, and SHALL never be high for two consecutive cycles except during auto-reload with reload_reg==1.
REQ-027 Timing: with load value N, cnt SHALL read N, N-1, ..., 1 in consecutive cycles, then 0 (or N on reload) with done=1; this is N edges after the load edge, absent pause.
REQ-028 cnt SHALL never wrap from 0 to all-ones; underflow is unreachable.
REQ-029 busy SHALL be decoded combinationally from the state register only.

Reset
REQ-030 While resn=0, the block SHALL immediately, independent of clk, force cnt=0, reload_reg=0, done=0, state=IDLE and busy=0.
REQ-031 On resn deassertion, the block SHALL remain in IDLE until the first accepted start.
REQ-032 Reset mid-run SHALL discard the run without any done pulse.

Verification
REQ-033 The bench SHALL check: start, load_val=3, auto_reload=0 -> cnt 3,2,1,0; done=1 only in the cnt=0 cycle; busy 1,1,1,0.
REQ-034 The bench SHALL check: load_val=15, auto_reload=1, 32 cycles -> cnt 15..1,15..1,15,14; done pulses exactly twice, 15 cycles apart.
REQ-035 The bench SHALL check: pause=1 for 2 edges with cnt=4 -> cnt 4,4,4 then 3; busy stays 1; no done.
REQ-036 The bench SHALL check: abort at cnt=2 -> cnt=0, IDLE, done stays 0; start with load_val=0 -> single done pulse, busy stays 0.
REQ-037 The bench SHALL check: start with load_val=9 while cnt=5 in RUN -> ignored, count continues 4,3.
REQ-038 The bench SHALL check: resn=0 mid-clock-period at cnt=6 -> cnt=0 and busy=0 before the next clk edge; no done.

Source files
------------

// File: rtl/countdown_timer.sv
// Countdown timer: loads a start value, counts down to terminal count and
// emits a one-cycle done pulse, with optional auto-reload, pause and abort.
// The decrement is built as an explicit ripple of half-subtractor cells.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             done_nxt;

    // Ripple decrementer: bit 0 subtracts constant 1, every higher bit
    // subtracts the borrow coming out of the bit below it.
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] cnt_dec;

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_half_sub
        assign cnt_dec[i] = cnt[i] ^ borrow[i];
        if (i < WIDTH - 1) begin : g_borrow
            assign borrow[i+1] = ~cnt[i] & borrow[i];
        end
    end

    // busy comes from the state register alone, so it never glitches on inputs.
    assign busy = (state == RUN) || (state == PAUSED);

    // Next-state and next-count decision; abort beats start beats pause.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        cnt_nxt    = cnt;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;

        if (abort) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (load_val != '0) begin
                            cnt_nxt    = load_val;
                            reload_nxt = load_val;
                            state_nxt  = RUN;
                        end else begin
                            // Zero-length run: immediate done, never busy.
                            cnt_nxt  = '0;
                            done_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (cnt > ONE) begin
                        cnt_nxt = cnt_dec;
                    end else begin
                        // Terminal edge; cnt==0 in RUN is unreachable but is
                        // treated the same way so the counter can never wrap.
                        done_nxt = 1'b1;
                        if (auto_reload) begin
                            cnt_nxt = reload_reg;
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state      <= IDLE;
            cnt        <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, regardless of statement order.
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            reload_reg <= reload_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with constant
// expectations plus randomized traffic checked against a behavioural model.
module tb_countdown_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             resn;
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    // Behavioural model: a countdown value, whether a run is active, whether
    // it is held, and the value to reload at terminal count.
    int m_cnt;
    int m_reload;
    bit m_active;
    bit m_held;
    bit m_done;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .resn       (resn),
        .start      (start),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .pause      (pause),
        .abort      (abort),
        .cnt        (cnt),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_reload = 0;
        m_active = 0;
        m_held   = 0;
        m_done   = 0;
    endtask

    // Advance the model by one clock edge using the current input values.
    task automatic model_edge();
        m_done = 0;
        if (abort) begin
            m_cnt    = 0;
            m_active = 0;
            m_held   = 0;
        end else if (!m_active) begin
            if (start) begin
                if (load_val != 0) begin
                    m_cnt    = load_val;
                    m_reload = load_val;
                    m_active = 1;
                end else begin
                    m_cnt  = 0;
                    m_done = 1;
                end
            end
        end else if (m_held) begin
            if (!pause) m_held = 0;
        end else if (pause) begin
            m_held = 1;
        end else if (m_cnt == 1) begin
            m_done = 1;
            if (auto_reload) begin
                m_cnt = m_reload;
            end else begin
                m_cnt    = 0;
                m_active = 0;
            end
        end else begin
            m_cnt = m_cnt - 1;
        end
    endtask

    // One clock edge: update the model, then compare just after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("cnt", cnt, m_cnt);
        check("busy", busy, m_active);
        check("done", done, m_done);
    endtask

    // Assert reset in the middle of a clock period and confirm it acts at once.
    task automatic reset_mid_period();
        #2;
        resn = 1'b0;
        #1;
        check("rst_cnt", cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        model_reset();
        #1;
        resn = 1'b1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        auto_reload = 1'b0;
        load_val    = '0;
    endtask

    task automatic kick(input int val, input bit reload);
        start       = 1'b1;
        load_val    = WIDTH'(val);
        auto_reload = reload;
        step();
        start = 1'b0;
    endtask

    task automatic clean_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    int exp_cnt3[4]  = '{3, 2, 1, 0};
    int exp_busy3[4] = '{1, 1, 1, 0};
    int exp_done3[4] = '{0, 0, 0, 1};
    int done_idx[$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resn     = 1'b0;
        idle_inputs();
        model_reset();

        #2;
        check("reset_cnt", cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        #10;
        resn = 1'b1;
        step();

        // Simple run of 3 with no reload.
        kick(3, 0);
        check("seq3_cnt", cnt, exp_cnt3[0]);
        check("seq3_busy", busy, exp_busy3[0]);
        check("seq3_done", done, exp_done3[0]);
        for (int i = 1; i < 4; i++) begin
            step();
            check("seq3_cnt", cnt, exp_cnt3[i]);
            check("seq3_busy", busy, exp_busy3[i]);
            check("seq3_done", done, exp_done3[i]);
        end
        step();
        check("seq3_done_after", done, 0);

        // Auto-reload of 15 over 32 observed cycles.
        done_idx.delete();
        kick(15, 1);
        check("rl_cnt", cnt, 15);
        for (int k = 1; k < 32; k++) begin
            step();
            check("rl_cnt", cnt, 15 - (k % 15));
            if (done) done_idx.push_back(k);
        end
        check("rl_done_count", done_idx.size(), 2);
        if (done_idx.size() == 2) check("rl_done_spacing", done_idx[1] - done_idx[0], 15);
        auto_reload = 1'b0;
        clean_abort();

        // Pause for two edges at cnt=4.
        kick(6, 0);
        step();
        step();
        check("pause_pre", cnt, 4);
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("pause_cnt", cnt, 4);
            check("pause_busy", busy, 1);
        end
        pause = 1'b0;
        step();
        check("pause_resume_cnt", cnt, 4);
        step();
        check("pause_dec_cnt", cnt, 3);
        check("pause_no_done", done, 0);
        clean_abort();

        // Abort at cnt=2, then a zero-length start.
        kick(5, 0);
        repeat (3) step();
        check("abort_pre", cnt, 2);
        abort = 1'b1;
        step();
        check("abort_cnt", cnt, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        abort = 1'b0;
        step();
        check("abort_done_after", done, 0);
        kick(0, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        step();
        check("zero_done_after", done, 0);
        check("zero_busy_after", busy, 0);

        // Start while running is ignored.
        kick(8, 0);
        repeat (3) step();
        check("ign_pre", cnt, 5);
        start    = 1'b1;
        load_val = WIDTH'(9);
        step();
        check("ign_cnt", cnt, 4);
        start = 1'b0;
        step();
        check("ign_cnt2", cnt, 3);
        clean_abort();

        // Asynchronous reset mid-period at cnt=6.
        kick(9, 0);
        repeat (3) step();
        check("arst_pre", cnt, 6);
        reset_mid_period();
        step();
        check("arst_idle_busy", busy, 0);
        check("arst_idle_done", done, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            abort       = ($urandom_range(0, 24) == 0);
            start       = ($urandom_range(0, 3) == 0);
            pause       = ($urandom_range(0, 4) == 0);
            auto_reload = $urandom_range(0, 1);
            load_val    = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            if ($urandom_range(0, 7) == 0) load_val = WIDTH'($urandom_range(0, 2));
            step();
            if ($urandom_range(0, 99) == 0) reset_mid_period();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
